// File: rtl/serial_add_pkg.sv
// ============================================================================
// Module : serial_add_pkg
// Brief  : Shared constants for the bit-serial adder controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

    localparam int unsigned SA_DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Bit counter must stay at least one bit wide even for WIDTH=1.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fa.sv
// ============================================================================
// Module : fa
// Brief  : One-bit full adder, the shared serial datapath element.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module : serial_add_ctrl
// Brief  : Schedules one full adder over WIDTH-bit operands, LSB first.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW     = cnt_width(WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_ws;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_ws_next;

    fa u_fa (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    // Sum bits enter at the MSB so that after WIDTH steps bit 0 holds the LSB.
    assign w_ws_next = (r_ws >> 1) | (WIDTH'(w_fa_sum) << (WIDTH - 1));

    // Busy/done are registered from the next state so outputs stay flop-driven.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_RUN);
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_step   = (r_state == ST_RUN);
        w_last   = w_step && (r_cnt == C_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_ws    <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_sa    <= a;
            r_sb    <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_sa    <= r_sa >> 1;
            r_sb    <= r_sb >> 1;
            r_ws    <= w_ws_next;
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_ws_next;
                r_cout <= w_fa_cout;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

`default_nettype wire
